// File: rtl/inst_fetch_unit.sv
// Fetch front-end: sequential PC generation, single-outstanding memory fetch, prefetch FIFO to IDU.
// Optional perf counters enabled by defining IFU_PERF_EN.
module inst_fetch_unit #(
  parameter int unsigned          XLEN       = 32,
  parameter logic [XLEN-1:0]      RESET_PC   = 'h8000_0000,
  parameter int unsigned          FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  input  logic            redirect_valid,
`ifdef IFU_PERF_EN
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_stall_cnt,
`endif
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_drop;
  logic [XLEN-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]     r_fifo_inst [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [AW:0]     w_count_next;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_accept      = (r_state == S_REQ) && mem_req_ready;
  assign w_push        = (r_state == S_WAIT) && mem_rsp_valid && !r_drop && !redirect_valid;
  assign w_pop         = (r_count != '0) && out_ready;
  assign w_count_next  = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);

  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_addr  = r_fetch_pc;
  assign out_valid     = (r_count != '0);
  assign out_pc        = out_valid ? r_fifo_pc[r_rd_ptr]   : '0;
  assign out_inst      = out_valid ? r_fifo_inst[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_drop     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= w_redirect_pc;
      // An in-flight fetch cannot be cancelled, so its response is swallowed via r_drop.
      unique case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_drop  <= 1'b0;
        end
        S_REQ: begin
          r_state <= w_accept ? S_WAIT : S_REQ;
          r_drop  <= w_accept;
        end
        S_WAIT: begin
          r_state <= mem_rsp_valid ? S_REQ : S_WAIT;
          r_drop  <= !mem_rsp_valid;
        end
        default: r_state <= S_IDLE;
      endcase
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]   <= r_req_pc;
        r_fifo_inst[r_wr_ptr] <= mem_rsp_data;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;

      unique case (r_state)
        S_IDLE: begin
          if (w_count_next < DEPTH_C) r_state <= S_REQ;
        end
        S_REQ: begin
          if (w_accept) begin
            r_state    <= S_WAIT;
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            r_drop  <= 1'b0;
            r_state <= (w_count_next < DEPTH_C) ? S_REQ : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_push)         perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (!out_valid)     perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a small fixed-latency memory model.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // memory model state
  logic        pend;
  int          cnt;
  int          lat;
  logic [31:0] paddr;

  inst_fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h8000_0000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .redirect_valid(redirect_valid),
`ifdef IFU_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; memory answers lat cycles after accept with data = ~addr.
  task automatic cyc();
    logic        acc;
    logic        rsp_was;
    logic        rst_was;
    logic [31:0] a;
    acc     = mem_req_valid && mem_req_ready;
    rsp_was = mem_rsp_valid;
    rst_was = rst;
    a       = mem_req_addr;
    @(posedge clk);
    #1;
    if (rsp_was) pend = 1'b0;
    if (acc === 1'b1) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = a;
    end
    if (rst_was) pend = 1'b0;
    if (pend && cnt != 0) cnt--;
    mem_rsp_valid = pend && (cnt == 0);
    mem_rsp_data  = mem_rsp_valid ? ~paddr : 32'h0;
  endtask

  initial begin
    rst = 1'b1; mem_req_ready = 1'b1; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    pend = 1'b0; cnt = 0; lat = 1; paddr = 32'h0;

    // reset and sequential fetch
    cyc(); cyc(); cyc();
    check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_req_addr",  mem_req_addr, 32'h8000_0000);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc",    out_pc, 32'h0);
    check("rst_out_inst",  out_inst, 32'h0);
`ifdef IFU_PERF_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rst_perf_flush", perf_flush_cnt, 32'h0);
`endif
    rst = 1'b0;
    cyc();
    check("req0_valid", {31'b0, mem_req_valid}, 32'd1);
    check("req0_addr",  mem_req_addr, 32'h8000_0000);
    cyc();
    check("ov_during_rsp", {31'b0, out_valid}, 32'd0);
    cyc();
    check("ov_after_rsp", {31'b0, out_valid}, 32'd1);
    check("head_pc0",     out_pc, 32'h8000_0000);
    check("head_inst0",   out_inst, 32'h7FFF_FFFF);
    check("req1_addr",    mem_req_addr, 32'h8000_0004);
    check("req1_valid",   {31'b0, mem_req_valid}, 32'd1);
    cyc(); cyc();
    check("req2_addr", mem_req_addr, 32'h8000_0008);
    cyc(); cyc();
    check("req3_addr", mem_req_addr, 32'h8000_000C);

    // FIFO fills after 4 fetches with no consumer
    cyc(); cyc();
    check("full_idle0", {31'b0, mem_req_valid}, 32'd0);
    check("full_head",  out_pc, 32'h8000_0000);
    cyc();
    check("full_idle1", {31'b0, mem_req_valid}, 32'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("pop_req_valid", {31'b0, mem_req_valid}, 32'd1);
    check("pop_req_addr",  mem_req_addr, 32'h8000_0010);
    check("pop_head_pc",   out_pc, 32'h8000_0004);
    check("pop_head_inst", out_inst, 32'h7FFF_FFFB);

    // request held while memory not ready
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'b0, mem_req_valid}, 32'd1);
      check("stall_addr",  mem_req_addr, 32'h8000_0010);
      cyc();
    end
    mem_req_ready = 1'b1;
    check("stall_6th_addr", mem_req_addr, 32'h8000_0010);
    cyc();
    check("stall_wait", {31'b0, mem_req_valid}, 32'd0);
    cyc();
    check("refull_idle", {31'b0, mem_req_valid}, 32'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("advance_once", mem_req_addr, 32'h8000_0014);

    // reset mid-transaction, then a stale response outside WAIT
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    check("mid_rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_addr",      mem_req_addr, 32'h8000_0000);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    cyc();
    check("stale_ignored0", {31'b0, out_valid}, 32'd0);
    cyc();
    check("stale_ignored1", {31'b0, out_valid}, 32'd0);
    check("stale_req_addr", mem_req_addr, 32'h8000_0000);

    // redirect while waiting; late response dropped
    mem_req_ready = 1'b1;
    lat = 4;
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    cyc();
    redirect_valid = 1'b0;
    check("drop_wait0", {31'b0, mem_req_valid}, 32'd0);
    cyc(); cyc();
    check("drop_wait_rsp", {31'b0, mem_req_valid}, 32'd0);
    check("drop_ov_rsp",   {31'b0, out_valid}, 32'd0);
    lat = 1;
    cyc();
    check("redir_req_valid", {31'b0, mem_req_valid}, 32'd1);
    check("redir_req_addr",  mem_req_addr, 32'h8000_0100);
    check("redir_fifo_empty", {31'b0, out_valid}, 32'd0);
    cyc(); cyc();
    check("redir_head_pc",   out_pc, 32'h8000_0100);
    check("redir_head_inst", out_inst, 32'h7FFF_FEFF);
    check("redir_next_addr", mem_req_addr, 32'h8000_0104);

    // redirect in the same cycle as a pop and an arriving response
    cyc();
    check("pre_flush_ov", {31'b0, out_valid}, 32'd1);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    cyc();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    check("flush_ov",        {31'b0, out_valid}, 32'd0);
    check("flush_req_valid", {31'b0, mem_req_valid}, 32'd1);
    check("flush_req_addr",  mem_req_addr, 32'h0000_0040);
    cyc();
    check("flush_ov_rsp", {31'b0, out_valid}, 32'd0);
    cyc();
    check("flush_head_pc",   out_pc, 32'h0000_0040);
    check("flush_head_inst", out_inst, 32'hFFFF_FFBF);
    check("flush_next_addr", mem_req_addr, 32'h0000_0044);

    // redirect in the accept cycle of a request
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    cyc();
    redirect_valid = 1'b0;
    check("acc_redir_ov",    {31'b0, out_valid}, 32'd0);
    check("acc_redir_wait",  {31'b0, mem_req_valid}, 32'd0);
    cyc();
    check("acc_redir_drop",  {31'b0, out_valid}, 32'd0);
    check("acc_redir_valid", {31'b0, mem_req_valid}, 32'd1);
    check("acc_redir_addr",  mem_req_addr, 32'h0000_0200);

    // redirect while request not accepted; PC wraps past 2^32
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    cyc();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    check("wd_valid", {31'b0, mem_req_valid}, 32'd1);
    check("wd_addr",  mem_req_addr, 32'hFFFF_FFFC);
    cyc(); cyc();
    check("wrap_addr",      mem_req_addr, 32'h0000_0000);
    check("wrap_head_pc",   out_pc, 32'hFFFF_FFFC);
    check("wrap_head_inst", out_inst, 32'h0000_0003);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
